imem_loader: RTL

// Writer side of the instruction-memory interface that the CPU fetch path reads (pc -> insc).
// - Receives a program as a byte stream over a valid/ready handshake.
// - Packs every 4 bytes into a 32-bit instruction and writes it to instruction RAM at consecutive word addresses.
// - Holds the CPU in reset until the whole image is loaded.
// - Sits between the board/host byte source and the instruction RAM write port plus the CPU reset input.

---
 rtl/imem_loader.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Writer side of the instruction-memory interface. Accepts a
//               program image as a byte stream over valid/ready, packs four
//               little-endian bytes per 32-bit instruction, writes each word
//               to consecutive instruction-RAM addresses and holds the CPU in
//               reset until the whole image is in place.
// Ports       : clk, rst_n              - clock, async active-low reset
//               start_i, num_words_i    - load request and image length
//               byte_valid_i/_data_i    - incoming byte stream
//               byte_ready_o            - loader accepts a byte this cycle
//               mem_we_o/_addr_o/_wdata_o - instruction RAM write port
//               busy_o, done_o, err_o   - load status levels
//               cpu_rst_n_o             - active-low CPU reset, high only in DONE
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W:0]   num_words_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              cpu_rst_n_o
);

  // Idle counter only needs to reach TIMEOUT.
  localparam int TO_W = $clog2(TIMEOUT + 1);

  localparam logic [ADDR_W:0] c_max_len  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] c_one_w    = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [TO_W-1:0] c_to_one   = TO_W'(1);
  localparam logic [TO_W-1:0] c_to_limit = TO_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  state_e            state_q;
  logic [1:0]        byte_cnt_q;
  logic [ADDR_W:0]   word_cnt_q;
  logic [ADDR_W:0]   len_q;
  logic [31:0]       word_q;
  logic [TO_W-1:0]   to_cnt_q;

  logic              byte_ready_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              cpu_rst_n_q;

  logic [ADDR_W:0]   start_len_d;
  logic              can_start_d;
  logic              xfer_d;
  logic [31:0]       word_d;
  logic [ADDR_W:0]   word_cnt_inc_d;
  logic [TO_W-1:0]   to_cnt_inc_d;

  always_comb begin
    // Requests beyond the RAM depth are clipped so word_cnt never wraps.
    start_len_d    = (num_words_i > c_max_len) ? c_max_len : num_words_i;
    can_start_d    = start_i &&
                     ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
    // byte_ready_q is only ever high in RECV, so it alone qualifies a transfer.
    xfer_d         = byte_valid_i & byte_ready_q;
    word_d         = word_q;
    word_d[{byte_cnt_q, 3'b000} +: 8] = byte_data_i;
    word_cnt_inc_d = word_cnt_q + c_one_w;
    to_cnt_inc_d   = to_cnt_q + c_to_one;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= '0;
      word_cnt_q   <= '0;
      len_q        <= '0;
      word_q       <= '0;
      to_cnt_q     <= '0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      cpu_rst_n_q  <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (can_start_d) begin
            err_q      <= 1'b0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            to_cnt_q   <= '0;
            len_q      <= start_len_d;
            if (start_len_d == '0) begin
              state_q      <= S_DONE;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
              cpu_rst_n_q  <= 1'b1;
              byte_ready_q <= 1'b0;
            end else begin
              state_q      <= S_RECV;
              busy_q       <= 1'b1;
              done_q       <= 1'b0;
              cpu_rst_n_q  <= 1'b0;
              byte_ready_q <= 1'b1;
            end
          end
        end

        S_RECV: begin
          if (xfer_d) begin
            word_q   <= word_d;
            to_cnt_q <= '0;
            if (byte_cnt_q == 2'd3) begin
              // Fourth byte: the write is issued from the merged word directly.
              state_q      <= S_WRITE;
              byte_ready_q <= 1'b0;
              mem_we_q     <= 1'b1;
              mem_addr_q   <= word_cnt_q[ADDR_W-1:0];
              mem_wdata_q  <= word_d;
              byte_cnt_q   <= '0;
            end else begin
              byte_cnt_q <= byte_cnt_q + 2'd1;
            end
          end else if (to_cnt_inc_d == c_to_limit) begin
            // Stalled stream: drop the partial word, keep the CPU in reset.
            state_q      <= S_ERR;
            err_q        <= 1'b1;
            busy_q       <= 1'b0;
            cpu_rst_n_q  <= 1'b0;
            byte_ready_q <= 1'b0;
            byte_cnt_q   <= '0;
            to_cnt_q     <= '0;
          end else begin
            to_cnt_q <= to_cnt_inc_d;
          end
        end

        S_WRITE: begin
          word_cnt_q <= word_cnt_inc_d;
          to_cnt_q   <= '0;
          if (word_cnt_inc_d == len_q) begin
            state_q      <= S_DONE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            cpu_rst_n_q  <= 1'b1;
            byte_ready_q <= 1'b0;
          end else begin
            state_q      <= S_RECV;
            byte_ready_q <= 1'b1;
          end
        end

        default: begin
          state_q      <= S_IDLE;
          byte_ready_q <= 1'b0;
          busy_q       <= 1'b0;
          done_q       <= 1'b0;
          err_q        <= 1'b0;
          cpu_rst_n_q  <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready_o = byte_ready_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign cpu_rst_n_o  = cpu_rst_n_q;

endmodule
`default_nettype wire
